// File: rtl/frame_buf_pkg.sv
// -----------------------------------------------------------------------------
// frame_buf_pkg
// Shared definitions for the frame buffer memory arbiter:
//   - arb_state_e : arbiter FSM states (IDLE / WR_GNT / RD_GNT)
//   - WR / RD     : encoding of the side that last held the grant
//   - ASSERT_L / DEASSERT_L : levels of the active-low request enables
//   - ASSERT_H / DEASSERT_H : levels of the active-high memory strobes
// -----------------------------------------------------------------------------
package frame_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_GNT = 2'd1,
        RD_GNT = 2'd2
    } arb_state_e;

    localparam logic WR = 1'b0;
    localparam logic RD = 1'b1;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/frame_buf_rd_credit.sv
// -----------------------------------------------------------------------------
// frame_buf_rd_credit
// Outstanding-read counter for the frame buffer arbiter.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset (count clears to 0)
//   inc_i       : one read beat accepted by memory this cycle
//   dec_i       : one read data beat returned this cycle
//   count_o     : number of reads issued but not yet returned
//   full_o      : count_o has reached MAX_OUTSTANDING
// -----------------------------------------------------------------------------
module frame_buf_rd_credit #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dec_eff;

    assign full_o  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign count_o = cnt_q;

    // A return with nothing outstanding is spurious and dropped, so the
    // counter can never wrap below zero.
    assign dec_eff = dec_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_eff && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!inc_i && dec_eff) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_buf_mem_arb.sv
// -----------------------------------------------------------------------------
// frame_buf_mem_arb
// Single-port memory arbiter between the frame buffer write and read address
// generators. Round-robin between the sides, bursts capped at MAX_BURST
// accepted beats per grant, reads throttled at MAX_OUTSTANDING in flight.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   wr_en_in, wr_addr_in    : write request (active-low) and address
//   rd_en_in, rd_addr_in    : read request (active-low) and address
//   mem_ready               : memory accepts the presented beat
//   mem_rd_valid            : one read data beat returned
//   mem_wr_en, mem_rd_en    : memory strobes (active-high)
//   mem_addr                : memory address (0 when idle)
//   wr_rdy, rd_rdy          : beat accepted for that side this cycle
//   rd_pending              : reads issued but not yet returned
// -----------------------------------------------------------------------------
module frame_buf_mem_arb
    import frame_buf_pkg::*;
#(
    parameter int ADDR_WIDTH      = 29,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en_in,
    input  logic [ADDR_WIDTH-1:0]                wr_addr_in,
    input  logic                                 rd_en_in,
    input  logic [ADDR_WIDTH-1:0]                rd_addr_in,
    input  logic                                 mem_ready,
    input  logic                                 mem_rd_valid,
    output logic                                 mem_wr_en,
    output logic                                 mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic                                 wr_rdy,
    output logic                                 rd_rdy,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_pending
);

    localparam int                BEAT_W     = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(MAX_BURST - 1);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic wreq;
    logic rreq;
    logic rd_full;

    assign wreq = (wr_en_in == ASSERT_L);
    assign rreq = (rd_en_in != DEASSERT_L) && !rd_full;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        mem_wr_en    = DEASSERT_H;
        mem_rd_en    = DEASSERT_H;
        mem_addr     = '0;
        wr_rdy       = DEASSERT_H;
        rd_rdy       = DEASSERT_H;

        unique case (state_q)
            IDLE: begin
                // Arbitration cycle: nothing is issued, the new grant
                // starts next cycle with a fresh burst count.
                beat_cnt_d = '0;
                if (wreq && rreq) begin
                    state_d = (last_grant_q == RD) ? WR_GNT : RD_GNT;
                end else if (wreq) begin
                    state_d = WR_GNT;
                end else if (rreq) begin
                    state_d = RD_GNT;
                end
            end

            WR_GNT: begin
                mem_wr_en = wreq;
                mem_addr  = wr_addr_in;
                wr_rdy    = wreq && mem_ready;
                if (wreq && mem_ready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // Release on request drop or on the beat that fills the
                // burst; hand over directly if the other side is waiting.
                if (!wreq || (mem_ready && beat_cnt_q == BURST_LAST)) begin
                    last_grant_d = WR;
                    if (rreq) begin
                        state_d    = RD_GNT;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            RD_GNT: begin
                mem_rd_en = rreq;
                mem_addr  = rd_addr_in;
                rd_rdy    = rreq && mem_ready;
                if (rreq && mem_ready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // rreq also drops when the credit counter fills, which
                // releases the grant the cycle after the last credit is used.
                if (!rreq || (mem_ready && beat_cnt_q == BURST_LAST)) begin
                    last_grant_d = RD;
                    if (wreq) begin
                        state_d    = WR_GNT;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= RD;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    frame_buf_rd_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_rd_credit (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (rd_rdy),
        .dec_i   (mem_rd_valid),
        .count_o (rd_pending),
        .full_o  (rd_full)
    );

endmodule

// File: tb/tb_frame_buf_mem_arb.sv
module tb_frame_buf_mem_arb;

    localparam int AW = 29;
    localparam int MB = 16;
    localparam int MO = 8;
    localparam logic [AW-1:0] WA = 29'h0ABCDEF;
    localparam logic [AW-1:0] RA = 29'h1234567;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en_in = 1'b1;
    logic [AW-1:0] wr_addr_in = '0;
    logic          rd_en_in = 1'b1;
    logic [AW-1:0] rd_addr_in = '0;
    logic          mem_ready = 1'b0;
    logic          mem_rd_valid = 1'b0;
    logic          mem_wr_en, mem_rd_en, wr_rdy, rd_rdy;
    logic [AW-1:0] mem_addr;
    logic [3:0]    rd_pending;

    always #5 clk = ~clk;

    frame_buf_mem_arb #(
        .ADDR_WIDTH      (AW),
        .MAX_BURST       (MB),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en_in     (wr_en_in),
        .wr_addr_in   (wr_addr_in),
        .rd_en_in     (rd_en_in),
        .rd_addr_in   (rd_addr_in),
        .mem_ready    (mem_ready),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .wr_rdy       (wr_rdy),
        .rd_rdy       (rd_rdy),
        .rd_pending   (rd_pending)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_wrdy = 0;
    int cnt_rrdy = 0;

    // Reference model: which side owns the port (0 none, 1 write, 2 read),
    // whether read went last, beats in this grant, reads in flight.
    int m_owner;
    bit m_last_rd;
    int m_beats;
    int m_pend;

    typedef struct {
        logic w, r, rdy, rv;
        logic ewr, erd, ewrdy, errdy;
        int   epend;
        int   asel;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic a, input logic b, input logic c,
                                       input logic d, input int p, input logic [AW-1:0] ad);
        return {27'b0, a, b, c, d, 4'(p), ad};
    endfunction

    function automatic logic [63:0] pack_out();
        return {27'b0, mem_wr_en, mem_rd_en, wr_rdy, rd_rdy, rd_pending, mem_addr};
    endfunction

    function automatic void model_reset();
        m_owner   = 0;
        m_last_rd = 1'b1;
        m_beats   = 0;
        m_pend    = 0;
    endfunction

    // Predict this cycle's outputs from the current model state, then advance.
    function automatic logic [63:0] model_cycle(input logic w, input logic [AW-1:0] wa,
                                                input logic r, input logic [AW-1:0] ra,
                                                input logic rdy, input logic rv);
        bit wants_w, wants_r, took_w, took_r, give_up;
        logic [63:0] e;
        wants_w = !w;
        wants_r = !r && (m_pend < MO);
        took_w  = 0;
        took_r  = 0;
        give_up = 0;
        e = pk(0, 0, 0, 0, m_pend, '0);
        if (m_owner == 0) begin
            m_beats = 0;
            if (wants_w && wants_r) m_owner = m_last_rd ? 1 : 2;
            else if (wants_w)       m_owner = 1;
            else if (wants_r)       m_owner = 2;
        end else if (m_owner == 1) begin
            took_w = wants_w && rdy;
            e = pk(wants_w, 0, took_w, 0, m_pend, wa);
            m_beats += took_w ? 1 : 0;
            give_up = !wants_w || (took_w && m_beats == MB);
            if (give_up) begin
                m_last_rd = 0;
                m_beats   = 0;
                m_owner   = wants_r ? 2 : 0;
            end
        end else begin
            took_r = wants_r && rdy;
            e = pk(0, wants_r, 0, took_r, m_pend, ra);
            m_beats += took_r ? 1 : 0;
            give_up = !wants_r || (took_r && m_beats == MB);
            if (give_up) begin
                m_last_rd = 1;
                m_beats   = 0;
                m_owner   = wants_w ? 1 : 0;
            end
        end
        if (took_r && !(rv && m_pend > 0)) m_pend++;
        else if (!took_r && rv && m_pend > 0) m_pend--;
        return e;
    endfunction

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic r,
                         input logic [AW-1:0] ra, input logic rdy, input logic rv);
        @(negedge clk);
        wr_en_in     = w;
        wr_addr_in   = wa;
        rd_en_in     = r;
        rd_addr_in   = ra;
        mem_ready    = rdy;
        mem_rd_valid = rv;
        #1;
        cnt_wrdy += int'(wr_rdy);
        cnt_rrdy += int'(rd_rdy);
    endtask

    task automatic step(input string tag, input logic w, input logic [AW-1:0] wa,
                        input logic r, input logic [AW-1:0] ra, input logic rdy, input logic rv);
        logic [63:0] e;
        drive(w, wa, r, ra, rdy, rv);
        e = model_cycle(w, wa, r, ra, rdy, rv);
        check(tag, pack_out(), e);
        if (mem_wr_en && mem_rd_en) check({tag, "_both_strobes"}, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en_in = 1'b1; rd_en_in = 1'b1; mem_ready = 1'b0; mem_rd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cnt_wrdy = 0;
        cnt_rrdy = 0;
    endtask

    initial begin
        tbl[0]  = '{0,1,1,0, 0,0,0,0, 0,0};
        tbl[1]  = '{0,1,1,0, 1,0,1,0, 0,1};
        tbl[2]  = '{0,1,0,0, 1,0,0,0, 0,1};
        tbl[3]  = '{1,1,1,0, 0,0,0,0, 0,1};
        tbl[4]  = '{1,0,1,0, 0,0,0,0, 0,0};
        tbl[5]  = '{1,0,1,0, 0,1,0,1, 0,2};
        tbl[6]  = '{1,0,1,0, 0,1,0,1, 1,2};
        tbl[7]  = '{1,1,1,1, 0,0,0,0, 2,2};
        tbl[8]  = '{1,1,1,1, 0,0,0,0, 1,0};
        tbl[9]  = '{1,1,1,1, 0,0,0,0, 0,0};
        tbl[10] = '{0,0,1,0, 0,0,0,0, 0,0};
        tbl[11] = '{0,0,1,0, 1,0,1,0, 0,1};
        tbl[12] = '{1,0,1,0, 0,0,0,0, 0,1};
        tbl[13] = '{1,0,1,0, 0,1,0,1, 0,2};
        tbl[14] = '{0,0,1,1, 0,1,0,1, 1,2};
        tbl[15] = '{0,1,1,0, 0,0,0,0, 1,2};
        tbl[16] = '{1,1,1,1, 0,0,0,0, 1,1};
        tbl[17] = '{1,1,1,0, 0,0,0,0, 0,0};

        // Reset state
        #2;
        check("reset_state", pack_out(), 64'd0);
        do_reset();

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            logic [AW-1:0] ea;
            drive(tbl[i].w, WA, tbl[i].r, RA, tbl[i].rdy, tbl[i].rv);
            ea = (tbl[i].asel == 1) ? WA : (tbl[i].asel == 2) ? RA : '0;
            check($sformatf("vec%0d", i), pack_out(),
                  pk(tbl[i].ewr, tbl[i].erd, tbl[i].ewrdy, tbl[i].errdy, tbl[i].epend, ea));
        end

        // Write only: 16-beat burst, one arbitration cycle, then more beats
        do_reset();
        for (int i = 0; i < 22; i++) step("wr_only", 0, WA, 1, RA, 1, 0);
        check("wr_only_beats", 64'(cnt_wrdy), 64'd20);

        // Both requesting: WR first, then alternating full bursts, no bubble
        do_reset();
        step("both_arb", 0, WA, 0, RA, 1, 1);
        step("both_first", 0, WA, 0, RA, 1, 1);
        check("both_first_is_wr", 64'(mem_wr_en), 64'd1);
        for (int i = 2; i < 34; i++) step("both", 0, WA, 0, RA, 1, 1);
        check("both_wr_beats", 64'(cnt_wrdy), 64'd17);
        check("both_rd_beats", 64'(cnt_rrdy), 64'd16);

        // Read only, no returns: throttle at MAX_OUTSTANDING
        do_reset();
        for (int i = 0; i < 12; i++) step("rd_throttle", 1, WA, 0, RA, 1, 0);
        check("rd_throttle_beats", 64'(cnt_rrdy), 64'd8);
        check("rd_throttle_pend", 64'(rd_pending), 64'd8);
        check("rd_throttle_strobe", 64'(mem_rd_en), 64'd0);
        step("rd_return", 1, WA, 0, RA, 1, 1);
        cnt_rrdy = 0;
        for (int i = 0; i < 3; i++) step("rd_refill", 1, WA, 0, RA, 1, 0);
        check("rd_refill_beats", 64'(cnt_rrdy), 64'd1);
        check("rd_refill_pend", 64'(rd_pending), 64'd8);

        // Stall at beat 3 for 5 cycles, then finish the burst
        do_reset();
        for (int i = 0; i < 4; i++) step("stall_pre", 0, WA, 1, RA, 1, 0);
        check("stall_pre_beats", 64'(cnt_wrdy), 64'd3);
        for (int i = 0; i < 5; i++) step("stall", 0, WA, 1, RA, 0, 0);
        check("stall_hold", {35'b0, mem_wr_en, mem_addr}, {35'b0, 1'b1, WA});
        for (int i = 0; i < 13; i++) step("stall_post", 0, WA, 1, RA, 1, 0);
        check("stall_total_beats", 64'(cnt_wrdy), 64'd16);
        step("stall_release", 0, WA, 1, RA, 1, 0);
        check("stall_release_idle", 64'(mem_wr_en), 64'd0);

        // Accepted read and a return in the same cycle at rd_pending=4
        do_reset();
        for (int i = 0; i < 5; i++) step("same_cyc_pre", 1, WA, 0, RA, 1, 0);
        step("same_cyc", 1, WA, 0, RA, 1, 1);
        check("same_cyc_accept", 64'(rd_rdy), 64'd1);
        step("same_cyc_post", 1, WA, 1, RA, 1, 0);
        check("same_cyc_pend", 64'(rd_pending), 64'd4);

        // Asynchronous reset in the middle of a read grant
        do_reset();
        for (int i = 0; i < 6; i++) step("rst_mid_pre", 1, WA, 0, RA, 1, 0);
        @(negedge clk);
        #1;
        check("rst_mid_before", {59'b0, mem_rd_en, rd_pending}, {59'b0, 1'b1, 4'd5});
        reset = 1'b0;
        #1;
        check("rst_mid_out", pack_out(), 64'd0);
        @(negedge clk);
        wr_en_in = 1'b1; rd_en_in = 1'b1; mem_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        step("rst_mid_arb", 0, WA, 0, RA, 1, 0);
        step("rst_mid_first", 0, WA, 0, RA, 1, 0);
        check("rst_mid_wr_wins", 64'(mem_wr_en), 64'd1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 logic'($urandom_range(0, 2) == 0), AW'($urandom),
                 logic'($urandom_range(0, 2) == 0), AW'($urandom),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
